// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types: data word, byte-enable mask and port identifier.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic {
    MEM_PORT_A = 1'b0,
    MEM_PORT_B = 1'b1
  } lc3b_mem_port;

endpackage

// File: rtl/mem_port_arbiter.sv
// Combinational round-robin choice between the fetch (A) and data (B) ports.
// The port that did not win last time wins a tie; last_grant is held by the parent.
module mem_port_arbiter
  import lc3b_types::*;
(
  input  logic         req_a,
  input  logic         req_b,
  input  lc3b_mem_port last_grant,
  output logic         grant_valid,
  output lc3b_mem_port grant_port
);

  // Pick the requesting port, alternating on a tie.
  always_comb begin
    grant_valid = req_a | req_b;
    grant_port  = MEM_PORT_A;
    if (req_a && req_b) begin
      grant_port = (last_grant == MEM_PORT_A) ? MEM_PORT_B : MEM_PORT_A;
    end else if (req_b) begin
      grant_port = MEM_PORT_B;
    end else begin
      grant_port = MEM_PORT_A;
    end
  end

endmodule

// File: rtl/dual_port_mem_responder.sv
// Single-ported word memory shared by two initiator ports; one access at a time,
// fixed LATENCY from grant to a one-cycle response pulse, byte-masked writes.
module dual_port_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read_a,
  input  logic          write_a,
  input  lc3b_mem_wmask wmask_a,
  input  lc3b_word      address_a,
  input  lc3b_word      wdata_a,
  output logic          resp_a,
  output lc3b_word      rdata_a,
  input  logic          read_b,
  input  logic          write_b,
  input  lc3b_mem_wmask wmask_b,
  input  lc3b_word      address_b,
  input  lc3b_word      wdata_b,
  output logic          resp_b,
  output lc3b_word      rdata_b
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  lc3b_mem_port           r_last_grant, r_port, w_port_next, w_grant_port;
  logic                   r_write, w_write_next;
  logic [ADDR_BITS-1:0]   r_idx, w_idx_next;
  lc3b_mem_wmask          r_wmask, w_wmask_next;
  lc3b_word               r_wdata, w_wdata_next;
  logic                   w_grant_valid, w_grant;
  logic                   w_req_a, w_req_b;
  logic                   w_resp_a_next, w_resp_b_next;
  lc3b_word               w_rdata_a_next, w_rdata_b_next, w_rd_word;
  logic [1:0]             w_mem_we;
  logic                   r_resp_a, r_resp_b;
  lc3b_word               r_rdata_a, r_rdata_b;
  lc3b_word               r_mem [DEPTH];
  logic                   w_unused_addr;

  // Byte-address bit 0 and the bits above the array index are don't-care.
  assign w_unused_addr = ^{address_a, address_b};

  assign w_req_a = read_a | write_a;
  assign w_req_b = read_b | write_b;

  mem_port_arbiter u_arbiter (
    .req_a       (w_req_a),
    .req_b       (w_req_b),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_port  (w_grant_port)
  );

  // Next-state logic; the granted port's request is captured only while IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_grant      = 1'b0;
    w_port_next  = r_port;
    w_write_next = r_write;
    w_idx_next   = r_idx;
    w_wmask_next = r_wmask;
    w_wdata_next = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_grant      = 1'b1;
          w_port_next  = w_grant_port;
          w_cnt_next   = CNT_LOAD;
          w_state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
          if (w_grant_port == MEM_PORT_A) begin
            w_write_next = write_a;
            w_idx_next   = address_a[ADDR_BITS:1];
            w_wmask_next = wmask_a;
            w_wdata_next = wdata_a;
          end else begin
            w_write_next = write_b;
            w_idx_next   = address_b[ADDR_BITS:1];
            w_wmask_next = wmask_b;
            w_wdata_next = wdata_b;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        w_cnt_next = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_next = ST_RESP;
        end else begin
          w_state_next = ST_BUSY;
        end
      end
      ST_RESP: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Response outputs are registered, so they are computed one cycle ahead of RESP.
  assign w_resp_a_next = (w_state_next == ST_RESP) && (w_port_next == MEM_PORT_A);
  assign w_resp_b_next = (w_state_next == ST_RESP) && (w_port_next == MEM_PORT_B);
  assign w_rd_word     = r_mem[w_idx_next];

  // Read data is driven only for a read response and is zero otherwise.
  always_comb begin
    w_rdata_a_next = '0;
    w_rdata_b_next = '0;
    if (w_resp_a_next && !w_write_next) begin
      w_rdata_a_next = w_rd_word;
    end else begin
      w_rdata_a_next = '0;
    end
    if (w_resp_b_next && !w_write_next) begin
      w_rdata_b_next = w_rd_word;
    end else begin
      w_rdata_b_next = '0;
    end
  end

  // Control state, arbitration history and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= MEM_PORT_B;
      r_resp_a     <= 1'b0;
      r_resp_b     <= 1'b0;
      r_rdata_a    <= '0;
      r_rdata_b    <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_last_grant <= w_grant ? w_grant_port : r_last_grant;
      r_resp_a     <= w_resp_a_next;
      r_resp_b     <= w_resp_b_next;
      r_rdata_a    <= w_rdata_a_next;
      r_rdata_b    <= w_rdata_b_next;
    end
  end

  // Captured access fields; meaningful only between grant and RESP.
  always_ff @(posedge clk) begin
    r_port  <= w_port_next;
    r_write <= w_write_next;
    r_idx   <= w_idx_next;
    r_wmask <= w_wmask_next;
    r_wdata <= w_wdata_next;
  end

  // A reset landing on RESP still suppresses the write.
  assign w_mem_we = {2{!reset && (r_state == ST_RESP) && r_write}} & r_wmask;

  // Per-byte write port of the word array.
  always_ff @(posedge clk) begin
    if (w_mem_we[0]) r_mem[r_idx][7:0]  <= r_wdata[7:0];
    if (w_mem_we[1]) r_mem[r_idx][15:8] <= r_wdata[15:8];
  end

  assign resp_a  = r_resp_a;
  assign resp_b  = r_resp_b;
  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench: vector table, directed multi-cycle sequences and a randomized
// run against a transaction-level model of the two-port responder.
module tb_dual_port_mem_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        read_a, write_a, read_b, write_b, resp_a, resp_b;
  logic [1:0]  wmask_a, wmask_b;
  logic [15:0] address_a, wdata_a, rdata_a, address_b, wdata_b, rdata_b;

  logic        l1_read_a, l1_write_a, l1_read_b, l1_write_b, l1_resp_a, l1_resp_b;
  logic [1:0]  l1_wmask_a, l1_wmask_b;
  logic [15:0] l1_address_a, l1_wdata_a, l1_rdata_a, l1_address_b, l1_wdata_b, l1_rdata_b;

  dual_port_mem_responder #(.ADDR_BITS(10), .LATENCY(3)) u_dut (
    .clk(clk), .reset(reset),
    .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
    .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
    .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b)
  );

  dual_port_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .read_a(l1_read_a), .write_a(l1_write_a), .wmask_a(l1_wmask_a), .address_a(l1_address_a),
    .wdata_a(l1_wdata_a), .resp_a(l1_resp_a), .rdata_a(l1_rdata_a),
    .read_b(l1_read_b), .write_b(l1_write_b), .wmask_b(l1_wmask_b), .address_b(l1_address_b),
    .wdata_b(l1_wdata_b), .resp_b(l1_resp_b), .rdata_b(l1_rdata_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          pb;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [1:0]  mask;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [12];

  // Reference model state: memory image, pending requests and the one active access.
  logic [15:0] mdl_mem [1024];
  bit          pend [2];
  bit          granted [2];
  bit          p_rd [2];
  bit          p_wq [2];
  logic [9:0]  p_idx [2];
  logic [1:0]  p_mask [2];
  logic [15:0] p_data [2];
  bit          act, a_wr;
  int          act_port, act_resp, next_free, last_g, g, rsel;
  logic [9:0]  a_idx;
  logic [1:0]  a_mask;
  logic [15:0] a_data, rd_val, init_val;
  bit          exp_ra, exp_rb;
  logic [15:0] exp_da, exp_db;
  logic [15:0] ma, mb, ga, gb;
  bit          both, seen;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive_port(input bit pb, input bit rd, input bit wr, input logic [15:0] addr,
                            input logic [1:0] mask, input logic [15:0] data);
    if (pb) begin
      read_b = rd; write_b = wr; address_b = addr; wmask_b = mask; wdata_b = data;
    end else begin
      read_a = rd; write_a = wr; address_a = addr; wmask_a = mask; wdata_a = data;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    drive_port(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    l1_read_a = 1'b0; l1_write_a = 1'b0; l1_read_b = 1'b0; l1_write_b = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One isolated access on the LATENCY=3 instance: latency, data, exclusivity, pulse width.
  task automatic do_access(input bit pb, input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [1:0] mask, input logic [15:0] data,
                           input logic [15:0] exp, input string name);
    int          lat;
    logic [15:0] got;
    bit          other;
    lat = -1; got = 16'h0; other = 1'b0;
    @(posedge clk); #1;
    drive_port(pb, rd, wr, addr, mask, data);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pb ? resp_a : resp_b) other = 1'b1;
      if (pb ? resp_b : resp_a) begin
        lat = k;
        got = pb ? rdata_b : rdata_a;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_rdata"}, {48'h0, got}, {48'h0, exp});
    check({name, "_other_resp"}, {63'h0, other}, 64'h0);
    @(posedge clk); #1;
    drive_port(pb, 1'b0, 1'b0, addr, mask, data);
    @(negedge clk);
    check({name, "_after_resp"}, {30'h0, resp_a, resp_b, rdata_a, rdata_b}, 64'h0);
  endtask

  function automatic logic [15:0] mk_addr(input logic [9:0] idx);
    logic [4:0] hi;
    logic       lo;
    hi = 5'($urandom_range(0, 31));
    lo = 1'($urandom_range(0, 1));
    return {hi, idx, lo};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    drive_port(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    l1_read_a = 1'b0; l1_write_a = 1'b0; l1_wmask_a = 2'b00; l1_address_a = 16'h0; l1_wdata_a = 16'h0;
    l1_read_b = 1'b0; l1_write_b = 1'b0; l1_wmask_b = 2'b00; l1_address_b = 16'h0; l1_wdata_b = 16'h0;
    repeat (2) @(posedge clk);
    do_reset();
    @(negedge clk);
    check("reset_outputs", {30'h0, resp_a, resp_b, rdata_a, rdata_b}, 64'h0);

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h0010, 2'b11, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0020, 2'b11, 16'hAAAA, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0020, 2'b01, 16'h1234, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, 16'hAA34};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0020, 2'b10, 16'h5600, 16'h0000};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h0021, 2'b00, 16'h0000, 16'h5634};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0020, 2'b00, 16'hFFFF, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, 16'h5634};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0840, 2'b11, 16'h7777, 16'h0000};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0000, 16'h7777};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h0030, 2'b11, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      do_access(vecs[i].pb, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].mask,
                vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Simultaneous reads: A wins after reset, B follows one IDLE cycle later.
    do_reset();
    ma = '0; mb = '0; ga = '0; gb = '0; both = 1'b0;
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0);
    drive_port(1'b1, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ma[k] = resp_a; mb[k] = resp_b;
      if (resp_a) ga = rdata_a;
      if (resp_b) gb = rdata_b;
      if (resp_a && resp_b) both = 1'b1;
      @(posedge clk); #1;
      if (ma[k]) drive_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      if (mb[k]) drive_port(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    end
    check("tie_resp_a_cycles", {48'h0, ma}, 64'h0008);
    check("tie_resp_b_cycles", {48'h0, mb}, 64'h0080);
    check("tie_rdata_a", {48'h0, ga}, 64'hBEEF);
    check("tie_rdata_b", {48'h0, gb}, 64'h5634);
    check("tie_both_resp", {63'h0, both}, 64'h0);

    // A requests continuously, B holds one request: grants go A, B, A, A.
    do_reset();
    ma = '0; mb = '0;
    @(posedge clk); #1;
    drive_port(1'b0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ma[k] = resp_a; mb[k] = resp_b;
      @(posedge clk); #1;
      if (k == 0) drive_port(1'b1, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0);
      if (mb[k]) drive_port(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    end
    drive_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    check("rr_resp_a_cycles", {48'h0, ma}, 64'h8808);
    check("rr_resp_b_cycles", {48'h0, mb}, 64'h0080);

    // Reset during BUSY of a write abandons it.
    seen = 1'b0;
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, 1'b1, 16'h0030, 2'b11, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    @(negedge clk);
    seen = seen | resp_a | resp_b;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {30'h0, resp_a, resp_b, rdata_a, rdata_b}, 64'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | resp_a | resp_b;
    end
    check("rst_mid_no_resp", {63'h0, seen}, 64'h0);
    do_access(1'b0, 1'b1, 1'b0, 16'h0030, 2'b00, 16'h0, 16'hFFFF, "rst_mid_readback");

    // LATENCY=1 instance: read+write counts as write, then a wrapped read.
    do_reset();
    @(posedge clk); #1;
    l1_read_b = 1'b1; l1_write_b = 1'b1; l1_wmask_b = 2'b11; l1_address_b = 16'h0002; l1_wdata_b = 16'hC0DE;
    @(negedge clk);
    check("l1_wr_cycle0", {62'h0, l1_resp_a, l1_resp_b}, 64'h0);
    @(negedge clk);
    check("l1_wr_resp", {30'h0, l1_resp_a, l1_resp_b, l1_rdata_a, l1_rdata_b}, {30'h0, 2'b01, 32'h0});
    @(posedge clk); #1;
    l1_write_b = 1'b0; l1_address_b = 16'h0802;
    @(negedge clk);
    check("l1_rd_cycle0", {62'h0, l1_resp_a, l1_resp_b}, 64'h0);
    @(negedge clk);
    check("l1_rd_resp", {30'h0, l1_resp_a, l1_resp_b, l1_rdata_a, l1_rdata_b}, {30'h0, 2'b01, 16'h0, 16'hC0DE});
    @(posedge clk); #1;
    l1_read_b = 1'b0;
    @(negedge clk);
    check("l1_after_resp", {30'h0, l1_resp_a, l1_resp_b, l1_rdata_a, l1_rdata_b}, 64'h0);

    // Known contents for the randomized region (word indices 0x40..0x4F).
    for (int i = 0; i < 16; i++) begin
      init_val = 16'($urandom);
      mdl_mem[64 + i] = init_val;
      do_access(1'b0, 1'b0, 1'b1, {5'd0, 10'(64 + i), 1'b0}, 2'b11, init_val, 16'h0,
                $sformatf("init%0d", i));
    end

    // Randomized traffic on both ports against the transaction-level model.
    do_reset();
    last_g = 1; next_free = 0; act = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; granted[p] = 1'b0;
    end
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[p]    = 1'b1;
            granted[p] = 1'b0;
            rsel       = int'($urandom_range(0, 2));
            p_rd[p]    = (rsel != 1);
            p_wq[p]    = (rsel != 0);
            p_idx[p]   = 10'(64 + $urandom_range(0, 15));
            p_mask[p]  = 2'($urandom_range(0, 3));
            p_data[p]  = 16'($urandom);
            drive_port(p == 1, p_rd[p], p_wq[p], mk_addr(p_idx[p]), p_mask[p], p_data[p]);
          end else begin
            drive_port(p == 1, 1'b0, 1'b0, 16'($urandom), 2'($urandom_range(0, 3)), 16'($urandom));
          end
        end else if (granted[p]) begin
          drive_port(p == 1, p_rd[p], p_wq[p], 16'($urandom), 2'($urandom_range(0, 3)), 16'($urandom));
        end
      end
      if (!act && n >= next_free && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) g = (last_g == 0) ? 1 : 0;
        else g = pend[0] ? 0 : 1;
        act = 1'b1; act_port = g; act_resp = n + 3; next_free = n + 4; last_g = g;
        granted[g] = 1'b1;
        a_wr = p_wq[g]; a_idx = p_idx[g]; a_mask = p_mask[g]; a_data = p_data[g];
      end
      @(negedge clk);
      exp_ra = 1'b0; exp_rb = 1'b0; exp_da = 16'h0; exp_db = 16'h0;
      if (act && n == act_resp) begin
        rd_val = a_wr ? 16'h0 : mdl_mem[a_idx];
        if (act_port == 0) begin
          exp_ra = 1'b1; exp_da = rd_val;
        end else begin
          exp_rb = 1'b1; exp_db = rd_val;
        end
        if (a_wr && a_mask[0]) mdl_mem[a_idx][7:0]  = a_data[7:0];
        if (a_wr && a_mask[1]) mdl_mem[a_idx][15:8] = a_data[15:8];
        act = 1'b0; pend[act_port] = 1'b0; granted[act_port] = 1'b0;
      end
      check($sformatf("rand_cycle%0d", n), {30'h0, resp_a, resp_b, rdata_a, rdata_b},
            {30'h0, exp_ra, exp_rb, exp_da, exp_db});
    end
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    drive_port(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
